histogram_equalizer_lut: RTL and testbench
==========================================

// Module: histogram_equalizer_lut
// PURPOSE
//  Reader/consumer of the per-frame histogram RAM. When a finished histogram is
//  announced, it reads all 256 bins and accumulates the CDF. From the CDF it builds a
//  256x8 equalization LUT in a shadow bank. At the next frame start it swaps that bank
//  in and remaps the live pixel stream through it. Sits between histogram RAM read
//  port and the downstream pixel pipeline (ahead of the 2D FIR).
// PARAMETERS
//  SCALE_Q24  13926  round(255*2^24/PIXELS_PER_FRAME); 32-bit unsigned (default 640x480)
// PORTS
//  clk           in   1   pixel clock; single clock domain
//  rst           in   1   reset, asynchronous, active-low
//  hist_ready    in   1   1-cycle pulse: histogram RAM holds a complete frame
//  hist_rd_en    out  1   read enable to histogram RAM
//  hist_addr     out  8   bin address to histogram RAM
//  hist_data     in   32  bin count; valid the cycle after hist_rd_en
//  in_pixel      in   8   input pixel
//  in_valid      in   1   input pixel qualifier
//  end_of_frame  in   1   high during last frame beat; falling edge = new frame start
//  out_pixel     out  8   remapped pixel
//  out_valid     out  1   out_pixel qualifier
//  lut_busy      out  1   high from build start until bank swap
//  lut_swapped   out  1   1-cycle pulse on the cycle after a bank swap
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; cdf=0; lut_loaded=0; bank_sel=0. LUT RAM not cleared.
//  FSM: IDLE -> READ on hist_ready. READ -> DRAIN after addr 255 is issued.
//   DRAIN -> PENDING after the last shadow write. PENDING -> IDLE on swap.
//   hist_ready is ignored (dropped) in READ/DRAIN/PENDING.
//  READ: cycle k=0..255 (k=0 is the cycle after hist_ready): hist_rd_en=1, hist_addr=k.
//   hist_rd_en=0 otherwise.
//  Pipeline per bin k:
//   k+1: cdf <= sat32(cdf + hist_data)  (saturates at 0xFFFFFFFF).
//   k+2: prod <= cdf * SCALE_Q24        (64-bit).
//   k+3: shadow[k] <= min(255, (prod + 2^23) >> 24).
//   Last write is at k=258. DRAIN exits, and PENDING is entered at 259.
//   cdf is cleared to 0 on IDLE->READ.
//  lut_busy: 1 from cycle 0 through the swap cycle inclusive.
//  Swap: in PENDING, on the edge where end_of_frame_dly=1 and end_of_frame=0:
//   - bank_sel toggles, lut_loaded<=1, FSM->IDLE.
//   - lut_swapped pulses 1 for the next cycle.
//   A swap edge that coincides with PENDING entry is honoured only from the next
//   edge onward. No swap ever occurs outside PENDING.
//  Pixel path, latency 1 (registered):
//   out_valid <= in_valid.
//   out_pixel <= lut_loaded ? active[in_pixel] : in_pixel.
//   A lookup sampled on the swap edge uses the old bank; later lookups use the new bank.
//   The pixel path never stalls and is unaffected by FSM state.
//  Reset mid-build: async clear aborts at once. hist_rd_en drops, FSM=IDLE, and the
//   identity mapping returns (lut_loaded=0). A later hist_ready rebuilds from bin 0.
// TESTING
//  1 No build after reset: in_pixel=0x37 with in_valid=1 -> out_pixel=0x37,
//    out_valid=1 one cycle later.
//  2 Uniform histogram, every bin=1200, then end_of_frame 1->0 ->
//    LUT[0]=1, LUT[255]=255, lut_swapped pulses once.
//  3 Single-bin histogram: bin0=307200, rest 0 -> every LUT entry=255.
//    Pixel 0x00 and pixel 0xAB both map to 0xFF.
//  4 Saturation: bin0=0xFFFFFFFF, bin1=5 -> cdf stays 0xFFFFFFFF, LUT[1..255]=255.
//    No wrap to small values.
//  5 hist_ready re-pulsed at READ cycle 100 -> ignored: exactly 256 reads, addr 0..255
//    in order. Drive end_of_frame falling at cycle 200 -> no swap.
//    Next falling edge after PENDING entry -> swap.
//  6 rst low at READ cycle 50 -> hist_rd_en=0, lut_busy=0 immediately, identity mapping.
//    Next hist_ready -> reads restart at addr 0.

Source files
------------

// File: rtl/histogram_equalizer_lut_if.sv
// Bundles the histogram RAM read port and the pixel stream of the equalizer LUT.
// slave is the equalizer's view, master is the surrounding pipeline's view.
interface histogram_equalizer_lut_if;
   localparam int unsigned PIX_W = 8;
   localparam int unsigned BIN_W = 32;

   logic             hist_ready;
   logic             hist_rd_en;
   logic [PIX_W-1:0] hist_addr;
   logic [BIN_W-1:0] hist_data;
   logic [PIX_W-1:0] in_pixel;
   logic             in_valid;
   logic             end_of_frame;
   logic [PIX_W-1:0] out_pixel;
   logic             out_valid;
   logic             lut_busy;
   logic             lut_swapped;

   modport slave (
      input  hist_ready, hist_data, in_pixel, in_valid, end_of_frame,
      output hist_rd_en, hist_addr, out_pixel, out_valid, lut_busy, lut_swapped
   );

   modport master (
      output hist_ready, hist_data, in_pixel, in_valid, end_of_frame,
      input  hist_rd_en, hist_addr, out_pixel, out_valid, lut_busy, lut_swapped
   );
endinterface

// File: rtl/histogram_equalizer_lut.sv
// Reads a finished histogram, accumulates its CDF into a shadow 256x8 LUT bank,
// swaps the bank in at the next frame start and remaps the live pixel stream.
module histogram_equalizer_lut #(
   parameter logic [31:0] SCALE_Q24 = 32'd13926
) (
   input logic                       clk,
   input logic                       rst,
   histogram_equalizer_lut_if.slave  bus
);
   localparam int unsigned PIX_W  = 8;
   localparam int unsigned BIN_W  = 32;
   localparam int unsigned PROD_W = 64;
   localparam int unsigned Q_W    = 40;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_READ    = 2'd1;
   localparam logic [1:0] ST_DRAIN   = 2'd2;
   localparam logic [1:0] ST_PENDING = 2'd3;

   logic [1:0]        state, state_nxt;
   logic              rd_en_nxt;
   logic [PIX_W-1:0]  addr_nxt;
   logic              cdf_clr;
   logic              swap;

   logic              v1, v2, v3;
   logic [PIX_W-1:0]  a1, a2, a3;
   logic [BIN_W-1:0]  cdf;
   logic [PROD_W-1:0] prod;
   logic              eof_dly;
   logic              bank_sel;
   logic              lut_loaded;

   logic [BIN_W:0]    cdf_sum;
   logic [Q_W-1:0]    prod_q;
   logic [PIX_W-1:0]  lut_val;

   // Two banks: {bank_sel, pixel} is active, {~bank_sel, bin} is the shadow being built
   logic [PIX_W-1:0]  lut_mem [512];

   assign cdf_sum = {1'b0, cdf} + {1'b0, bus.hist_data};
   assign prod_q  = Q_W'((prod + PROD_W'(64'h80_0000)) >> 24);
   assign lut_val = (|prod_q[Q_W-1:PIX_W]) ? 8'hFF : prod_q[PIX_W-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      rd_en_nxt = 1'b0;
      addr_nxt  = bus.hist_addr;
      cdf_clr   = 1'b0;
      swap      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.hist_ready) begin
               state_nxt = ST_READ;
               rd_en_nxt = 1'b1;
               addr_nxt  = '0;
               cdf_clr   = 1'b1;
            end
         end
         ST_READ: begin
            if (bus.hist_addr == 8'hFF) begin
               state_nxt = ST_DRAIN;
            end else begin
               rd_en_nxt = 1'b1;
               addr_nxt  = 8'(bus.hist_addr + 8'd1);
            end
         end
         ST_DRAIN: begin
            if (v3 && (a3 == 8'hFF)) state_nxt = ST_PENDING;
         end
         ST_PENDING: begin
            if (eof_dly && !bus.end_of_frame) begin
               swap      = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Read port, CDF/scale pipeline and bank control
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.hist_rd_en  <= 1'b0;
         bus.hist_addr   <= '0;
         bus.lut_busy    <= 1'b0;
         bus.lut_swapped <= 1'b0;
         v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
         a1 <= '0;   a2 <= '0;   a3 <= '0;
         cdf        <= '0;
         prod       <= '0;
         eof_dly    <= 1'b0;
         bank_sel   <= 1'b0;
         lut_loaded <= 1'b0;
      end else begin
         bus.hist_rd_en  <= rd_en_nxt;
         bus.hist_addr   <= addr_nxt;
         bus.lut_busy    <= (state_nxt != ST_IDLE);
         bus.lut_swapped <= swap;
         v1 <= bus.hist_rd_en; a1 <= bus.hist_addr;
         v2 <= v1;             a2 <= a1;
         v3 <= v2;             a3 <= a2;
         if (cdf_clr)  cdf <= '0;
         else if (v1)  cdf <= cdf_sum[BIN_W] ? '1 : cdf_sum[BIN_W-1:0];
         if (v2) prod <= PROD_W'(cdf) * PROD_W'(SCALE_Q24);
         eof_dly <= bus.end_of_frame;
         if (swap) begin
            bank_sel   <= ~bank_sel;
            lut_loaded <= 1'b1;
         end
      end
   end

   // Shadow write; the LUT RAM is deliberately left uninitialised by reset
   always_ff @(posedge clk) begin
      if (v3) lut_mem[{~bank_sel, a3}] <= lut_val;
   end

   // Pixel path: the swap edge still samples the old bank_sel
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.out_pixel <= '0;
         bus.out_valid <= 1'b0;
      end else begin
         bus.out_valid <= bus.in_valid;
         bus.out_pixel <= lut_loaded ? lut_mem[{bank_sel, bus.in_pixel}] : bus.in_pixel;
      end
   end
endmodule

// File: tb/tb_histogram_equalizer_lut.sv
// Scoreboard bench for histogram_equalizer_lut: directed histograms, hand-computed
// LUT values, read-sequence and swap monitoring.
module tb_histogram_equalizer_lut;
   logic clk = 1'b0;
   logic rst;

   histogram_equalizer_lut_if bus();

   histogram_equalizer_lut #(.SCALE_Q24(32'd13926)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Histogram RAM model: data valid the cycle after the read enable
   logic [31:0] hist_mem [256];
   always @(posedge clk) begin
      if (bus.hist_rd_en) bus.hist_data <= hist_mem[bus.hist_addr];
   end

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] exp_q [$];
   int         rd_cnt = 0;
   int         addr_err = 0;
   int         swap_cnt = 0;
   logic       prev_rd = 1'b0;
   logic [7:0] last_addr = 8'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      logic [7:0] e;
      logic [7:0] want;
      forever begin
         @(negedge clk);
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL out_valid: got 1 with no pixel pending, required 0");
            end else begin
               e = exp_q.pop_front();
               check("out_pixel", 32'(bus.out_pixel), 32'(e));
            end
         end
         if (bus.hist_rd_en) begin
            want = prev_rd ? 8'(last_addr + 8'd1) : 8'd0;
            if (bus.hist_addr !== want) addr_err++;
            last_addr = bus.hist_addr;
            rd_cnt++;
         end
         prev_rd = bus.hist_rd_en;
         if (bus.lut_swapped) swap_cnt++;
      end
   endtask

   task automatic send_pixel(input logic [7:0] p, input logic [7:0] e);
      @(negedge clk);
      bus.in_pixel = p;
      bus.in_valid = 1'b1;
      exp_q.push_back(e);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic pulse_ready();
      @(negedge clk);
      bus.hist_ready = 1'b1;
      @(negedge clk);
      bus.hist_ready = 1'b0;
   endtask

   task automatic eof_fall();
      @(negedge clk);
      bus.end_of_frame = 1'b1;
      @(negedge clk);
      bus.end_of_frame = 1'b0;
   endtask

   task automatic fill_hist(input logic [31:0] v);
      for (int i = 0; i < 256; i++) hist_mem[i] = v;
   endtask

   // Full build: 256 ordered reads, busy through PENDING, one swap pulse, then idle
   task automatic do_build(input string tag);
      int r0, a0, s0;
      r0 = rd_cnt; a0 = addr_err;
      pulse_ready();
      repeat (5) @(negedge clk);
      check({tag, "_busy_build"}, 32'(bus.lut_busy), 32'd1);
      repeat (270) @(negedge clk);
      check({tag, "_read_count"}, 32'(rd_cnt - r0), 32'd256);
      check({tag, "_addr_order"}, 32'(addr_err - a0), 32'd0);
      check({tag, "_busy_pending"}, 32'(bus.lut_busy), 32'd1);
      s0 = swap_cnt;
      eof_fall();
      repeat (3) @(negedge clk);
      check({tag, "_swap_pulses"}, 32'(swap_cnt - s0), 32'd1);
      check({tag, "_busy_after_swap"}, 32'(bus.lut_busy), 32'd0);
   endtask

   initial begin
      #100us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int r0, a0, s0;
      fork
         monitor();
      join_none

      rst              = 1'b0;
      bus.hist_ready   = 1'b0;
      bus.in_pixel     = 8'd0;
      bus.in_valid     = 1'b0;
      bus.end_of_frame = 1'b0;
      fill_hist(32'd0);
      repeat (3) @(negedge clk);
      check("rst_hist_rd_en",  32'(bus.hist_rd_en),  32'd0);
      check("rst_hist_addr",   32'(bus.hist_addr),   32'd0);
      check("rst_out_valid",   32'(bus.out_valid),   32'd0);
      check("rst_out_pixel",   32'(bus.out_pixel),   32'd0);
      check("rst_lut_busy",    32'(bus.lut_busy),    32'd0);
      check("rst_lut_swapped", 32'(bus.lut_swapped), 32'd0);
      rst = 1'b1;

      // 1: identity before any build, latency one cycle
      send_pixel(8'h37, 8'h37);
      check("t1_out_valid", 32'(bus.out_valid), 32'd1);

      // 2: uniform 1200 per bin; LUT[k] = round(1200*(k+1)*13926/2^24)
      fill_hist(32'd1200);
      pulse_ready();
      send_pixel(8'h37, 8'h37);
      repeat (280) @(negedge clk);
      s0 = swap_cnt;
      eof_fall();
      repeat (3) @(negedge clk);
      check("t2_swap_pulses", 32'(swap_cnt - s0), 32'd1);
      send_pixel(8'h00, 8'd1);
      send_pixel(8'h01, 8'd2);
      send_pixel(8'h7F, 8'd127);
      send_pixel(8'hFF, 8'd255);

      // 3: everything in bin 0 -> all entries 255
      fill_hist(32'd0);
      hist_mem[0] = 32'd307200;
      do_build("t3");
      send_pixel(8'h00, 8'hFF);
      send_pixel(8'hAB, 8'hFF);

      // 4: CDF saturates instead of wrapping to 4
      fill_hist(32'd0);
      hist_mem[0] = 32'hFFFF_FFFF;
      hist_mem[1] = 32'd5;
      do_build("t4");
      send_pixel(8'h01, 8'hFF);
      send_pixel(8'h80, 8'hFF);
      send_pixel(8'hFF, 8'hFF);

      // 5: re-pulse during READ ignored, early frame edge ignored
      fill_hist(32'd0);
      hist_mem[255] = 32'd307200;
      r0 = rd_cnt; a0 = addr_err; s0 = swap_cnt;
      pulse_ready();
      repeat (100) @(negedge clk);
      bus.hist_ready = 1'b1;
      @(negedge clk);
      bus.hist_ready = 1'b0;
      repeat (99) @(negedge clk);
      eof_fall();
      repeat (5) @(negedge clk);
      check("t5_no_early_swap", 32'(swap_cnt - s0), 32'd0);
      check("t5_busy_early",    32'(bus.lut_busy),  32'd1);
      repeat (70) @(negedge clk);
      check("t5_read_count", 32'(rd_cnt - r0),     32'd256);
      check("t5_addr_order", 32'(addr_err - a0),   32'd0);
      eof_fall();
      repeat (3) @(negedge clk);
      check("t5_swap_pulses", 32'(swap_cnt - s0),  32'd1);
      send_pixel(8'h10, 8'h00);
      send_pixel(8'hFE, 8'h00);
      send_pixel(8'hFF, 8'hFF);

      // 6: reset mid-build aborts and restores identity; rebuild starts at bin 0
      fill_hist(32'd1200);
      pulse_ready();
      repeat (50) @(negedge clk);
      rst = 1'b0;
      #1;
      check("t6_rd_en_in_rst", 32'(bus.hist_rd_en), 32'd0);
      check("t6_busy_in_rst",  32'(bus.lut_busy),   32'd0);
      @(negedge clk);
      rst = 1'b1;
      send_pixel(8'h42, 8'h42);
      do_build("t6");
      send_pixel(8'h7F, 8'd127);
      send_pixel(8'h00, 8'd1);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
